// File: rtl/key_pkg.sv
// Shared types, key-code constants and the button-to-code priority mapping
// used by the key scanner.
package key_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE
   } state_e;

   localparam logic [2:0] KEY_CODE_NONE = 3'd0;
   localparam logic [2:0] KEY_CODE_1    = 3'd1;
   localparam logic [2:0] KEY_CODE_2    = 3'd2;
   localparam logic [2:0] KEY_CODE_3    = 3'd3;
   localparam logic [2:0] KEY_CODE_4    = 3'd4;
   localparam logic [2:0] KEY_CODE_5    = 3'd5;

   // Lowest code wins when several buttons are down.
   function automatic logic [2:0] key_arb(input logic [4:0] k);
      if      (k[4]) return KEY_CODE_1;
      else if (k[3]) return KEY_CODE_2;
      else if (k[1]) return KEY_CODE_3;
      else if (k[0]) return KEY_CODE_4;
      else if (k[2]) return KEY_CODE_5;
      else           return KEY_CODE_NONE;
   endfunction

   function automatic logic [4:0] code_mask(input logic [2:0] c);
      case (c)
         KEY_CODE_1: return 5'b10000;
         KEY_CODE_2: return 5'b01000;
         KEY_CODE_3: return 5'b00010;
         KEY_CODE_4: return 5'b00001;
         KEY_CODE_5: return 5'b00100;
         default:    return 5'b00000;
      endcase
   endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer bringing the raw push-button lines into the clk domain.
module key_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] key_in,
   output logic [4:0] key_sync
);

   logic [4:0] meta_q, meta_d;
   logic [4:0] sync_q, sync_d;

   always_comb begin
      meta_d = key_in;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign key_sync = sync_q;

endmodule

// File: rtl/key_scan_ctrl.sv
// Debounced 5-button scanner: arbitrates, debounces press and release, emits
// a one-cycle key_valid per press. Define KEY_SCAN_AUTO_REPEAT_EN for auto-repeat.
module key_scan_ctrl
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] key,
   output logic [2:0] key_out,
   output logic       key_valid,
   output logic       busy
);

   localparam int MAX_CYC = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [4:0] key_s;
   logic [2:0] code;

   state_e           state_q, state_d;
   logic [2:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       key_out_q, key_out_d;
   logic             key_valid_q, key_valid_d;

   key_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_in   (key),
      .key_sync (key_s)
   );

   assign code = key_arb(key_s);

`ifdef KEY_SCAN_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_TC = CNT_W'(REPEAT_CYCLES - 1);
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      key_out_d   = key_out_q;
      key_valid_d = 1'b0;
`ifdef KEY_SCAN_AUTO_REPEAT_EN
      rep_cnt_d   = rep_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            key_out_d = KEY_CODE_NONE;
            if (code != KEY_CODE_NONE) begin
               cand_d  = code;
               cnt_d   = '0;
               state_d = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (code != cand_q) begin
               state_d = ST_IDLE;
            end else if (cnt_q == DEB_TC) begin
               key_out_d   = cand_q;
               key_valid_d = 1'b1;
               state_d     = ST_PRESSED;
`ifdef KEY_SCAN_AUTO_REPEAT_EN
               rep_cnt_d   = '0;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_PRESSED: begin
            // Only the captured button matters here; others are ignored.
            if ((key_s & code_mask(key_out_q)) == 5'b0) begin
               cnt_d   = '0;
               state_d = ST_RELEASE;
            end
`ifdef KEY_SCAN_AUTO_REPEAT_EN
            else if (rep_cnt_q == REP_TC) begin
               key_valid_d = 1'b1;
               rep_cnt_d   = '0;
            end else begin
               rep_cnt_d = rep_cnt_q + 1'b1;
            end
`endif
         end
         ST_RELEASE: begin
            if (key_s != 5'b0) begin
               cnt_d = '0;
            end else if (cnt_q == DEB_TC) begin
               key_out_d = KEY_CODE_NONE;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cand_q      <= KEY_CODE_NONE;
         cnt_q       <= '0;
         key_out_q   <= KEY_CODE_NONE;
         key_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         key_out_q   <= key_out_d;
         key_valid_q <= key_valid_d;
      end
   end

`ifdef KEY_SCAN_AUTO_REPEAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rep_cnt_q <= '0;
      else        rep_cnt_q <= rep_cnt_d;
   end
`endif

   assign key_out   = key_out_q;
   assign key_valid = key_valid_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
